const_div_seq: RTL and testbench

//   Parametrised sequential divider by a compile-time constant D: returns quotient and

---
 rtl/const_div_seq.sv | 116 +++++++++++
 tb/tb_const_div_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_div_seq.sv
// Radix-2^K sequential divide by constant D: N=W/K RUN cycles, result valid N cycles after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one op per N+2 cycles).
module const_div_seq #(
  parameter int W = 16,
  parameter int D = 23,
  parameter int K = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_q,
  output logic [$clog2(D)-1:0]  out_r,
  output logic                  busy
);

  localparam int RW = $clog2(D);
  localparam int N  = W / K;
  localparam int TW = RW + K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] DIV = TW'(D);

  if ((K < 1) || (K > W) || ((W % K) != 0) || (D < 2)) begin : g_param_check
    $fatal(1, "const_div_seq: illegal W/K/D combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    xs_q, xs_d;
  logic [RW-1:0]   r_q, r_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [RW-1:0]   rem_q, rem_d;

  logic [TW-1:0]   t;
  logic [K-1:0]    digit;
  logic [RW-1:0]   r_step;
  logic [W-1:0]    acc_step;

  // t < D*2^K because r_q < D, so the digit always fits in K bits.
  always_comb begin
    t        = {r_q, xs_q[W-1 -: K]};
    digit    = K'(t / DIV);
    r_step   = RW'(t % DIV);
    acc_step = W'({acc_q, digit});
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    r_d     = r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xs_d    = in_x;
          r_d     = '0;
          acc_d   = '0;
          cnt_d   = CW'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        xs_d  = W'({xs_q, {K{1'b0}}});
        r_d   = r_step;
        acc_d = acc_step;
        if (cnt_q == '0) begin
          quot_d  = acc_step;
          rem_d   = r_step;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_q     = quot_q;
  assign out_r     = rem_q;

endmodule

// File: tb/tb_const_div_seq.sv
// Bench for const_div_seq: directed handshake/latency/reset cases on the default
// configuration plus randomized runs on four parameter sets, all scoreboard-checked.
module tb_const_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit finished = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- main instance (W=16, D=23, K=4) ----------------
  typedef struct { longint q; longint r; } exp_t;
  exp_t exp_q[$];

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_x, out_q;
  logic [4:0]  out_r;
  bit          rand_rdy = 0;
  bit          main_done = 0;

  const_div_seq #(.W(16), .D(23), .K(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("main_spurious_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("main_q", longint'(out_q), e.q);
        check("main_r", longint'(out_r), e.r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [15:0] x);
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin tick(); n++; end
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
    in_x     = 16'($urandom);
  endtask

  task automatic push(input longint q, input longint r);
    exp_t e;
    e.q = q;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin tick(); n++; end
    check(nm, exp_q.size(), 0);
  endtask

  longint t2_x[4] = '{22, 23, 1234, 65535};
  longint t2_q[4] = '{0, 1, 53, 2849};
  longint t2_r[4] = '{22, 0, 15, 8};

  initial begin
    int n;
    bit seen;
    logic [15:0] x;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_q", out_q, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // T1: zero operand, latency
    out_ready = 1'b1;
    push(0, 0);
    send(16'd0);
    check("t1_busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("t1_latency", n, 4);
    tick();

    // T2: directed table
    for (int i = 0; i < 4; i++) begin
      push(t2_q[i], t2_r[i]);
      send(16'(t2_x[i]));
    end
    drain("t2_drain");

    // T3: consumer stall, in_valid pulses ignored
    out_ready = 1'b0;
    push(21, 17);
    send(16'd500);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x = 16'($urandom);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_q", out_q, 21);
      check("t3_hold_r", out_r, 17);
      check("t3_in_ready_low", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_idle_in_ready", in_ready, 1);
    check("t3_idle_out_valid", out_valid, 0);
    repeat (6) tick();
    check("t3_no_phantom_op", busy, 0);

    // T4: in_valid held high across two operands
    push(4, 8);
    push(8, 16);
    in_valid = 1'b1;
    in_x = 16'd100;
    tick();
    in_x = 16'd200;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("t4_gap_cycles", n, 5);
    tick();
    in_valid = 1'b0;
    check("t4_second_accepted", busy, 1);
    drain("t4_drain");

    // T5: reset during second RUN cycle
    send(16'd300);
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_out_q", out_q, 0);
    check("t5_out_r", out_r, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("t5_no_valid_after_release", seen, 0);
    push(33, 18);
    send(16'd777);
    drain("t5_drain");

    // Random operands with random consumer stalls
    rand_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) x = 16'd0;
      else if (i == 1) x = 16'hFFFF;
      else if (i == 2) x = 16'd22;
      else x = 16'($urandom);
      push(longint'(x) / 23, longint'(x) % 23);
      send(x);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain("rand_drain");
    rand_rdy = 0;
    main_done = 1;
  end

  // ---------------- randomized parameter sets ----------------
  logic gen_rst_n;
  initial begin
    gen_rst_n = 1'b0;
    #23 gen_rst_n = 1'b1;
  end

  localparam int GW_A [4] = '{16, 16, 24, 12};
  localparam int GD_A [4] = '{23, 23, 7, 3};
  localparam int GK_A [4] = '{4, 1, 8, 12};

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int GW  = GW_A[g];
    localparam int GD  = GD_A[g];
    localparam int GK  = GK_A[g];
    localparam int GRW = $clog2(GD);

    logic           g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_busy;
    logic [GW-1:0]  g_in_x, g_out_q;
    logic [GRW-1:0] g_out_r;
    longint         xq[$];
    bit             done = 0;

    const_div_seq #(.W(GW), .D(GD), .K(GK)) u_dut (
      .clk(clk), .rst_n(gen_rst_n),
      .in_valid(g_in_valid), .in_ready(g_in_ready), .in_x(g_in_x),
      .out_valid(g_out_valid), .out_ready(g_out_ready),
      .out_q(g_out_q), .out_r(g_out_r), .busy(g_busy)
    );

    task automatic gtick();
      @(posedge clk);
      #1;
      g_out_ready = ($urandom_range(0, 2) != 0);
    endtask

    always @(negedge clk) begin
      if (gen_rst_n && g_out_valid && g_out_ready) begin
        if (xq.size() == 0) begin
          check($sformatf("cfg%0d_spurious_result", g), 1, 0);
        end else begin
          longint xv;
          xv = xq.pop_front();
          check($sformatf("cfg%0d_qd_plus_r", g), longint'(g_out_q) * GD + longint'(g_out_r), xv);
          check($sformatf("cfg%0d_r_lt_d", g), longint'(g_out_r) < GD, 1);
        end
      end
    end

    initial begin
      int n;
      logic [GW-1:0] x;
      g_in_valid = 1'b0; g_in_x = '0; g_out_ready = 1'b0;
      wait (gen_rst_n);
      for (int i = 0; i < 120; i++) begin
        if (i == 0) x = '0;
        else if (i == 1) x = '1;
        else x = GW'($urandom);
        n = 0;
        while (!g_in_ready && n < 1000) begin gtick(); n++; end
        xq.push_back(longint'(x));
        g_in_valid = 1'b1;
        g_in_x = x;
        gtick();
        g_in_valid = 1'b0;
        g_in_x = GW'($urandom);
        repeat ($urandom_range(0, 2)) gtick();
      end
      n = 0;
      while (xq.size() > 0 && n < 3000) begin gtick(); n++; end
      check($sformatf("cfg%0d_drain", g), xq.size(), 0);
      done = 1;
    end
  end

  // ---------------- completion / watchdog ----------------
  initial begin
    wait (main_done && g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done);
    if (!finished) begin
      finished = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #400000;
    if (!finished) begin
      finished = 1;
      bad++;
      $display("FAIL watchdog: got still_running expected all_streams_done");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
